// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if
//   Bundles the display-side signals of the 7-segment scan driver.
//   master : the source of the digit codes and alarm flag (display selector / bench)
//   slave  : the scan driver itself
//   Signals:
//     l1..l4      digit codes, l1 = rightmost digit
//     colon       light the DP of digit 2
//     alarm_state alarm currently sounding
//     seg_n       segments a..g, active-low, [0]=a
//     dp_n        decimal point, active-low
//     an_n        digit enables, active-low, [i] = digit i
//     buzz        buzzer drive
interface seg7_scan_driver_if;
  logic [3:0] l1;
  logic [3:0] l2;
  logic [3:0] l3;
  logic [3:0] l4;
  logic       colon;
  logic       alarm_state;
  logic [6:0] seg_n;
  logic       dp_n;
  logic [3:0] an_n;
  logic       buzz;

  modport master (
    output l1, l2, l3, l4, colon, alarm_state,
    input  seg_n, dp_n, an_n, buzz
  );

  modport slave (
    input  l1, l2, l3, l4, colon, alarm_state,
    output seg_n, dp_n, an_n, buzz
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexes four digit codes onto a common-anode 4-digit 7-segment
//   display, with a blanking gap at the start of every digit slot, and
//   generates the gated alarm buzzer tone.
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous, active-high
//     bus    seg7_scan_driver_if.slave (digit codes, colon, alarm in;
//            seg_n, dp_n, an_n, buzz out; all outputs registered)
module seg7_scan_driver #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int SCAN_HZ   = 1000,
  parameter int BLANK_CYC = 50,
  parameter int TONE_HZ   = 2000,
  parameter int BEEP_DIV  = 10
) (
  input logic               clk,
  input logic               reset,
  seg7_scan_driver_if.slave bus
);

  localparam int SLOT_CYC  = CLK_HZ / SCAN_HZ;
  localparam int DRIVE_CYC = SLOT_CYC - BLANK_CYC;
  localparam int HALF_CYC  = CLK_HZ / (2 * TONE_HZ);
  localparam int STEP_CYC  = CLK_HZ / BEEP_DIV;

  localparam int SLOT_W = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam int TONE_W = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
  localparam int STEP_W = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam int BEEP_W = (BEEP_DIV > 8) ? $clog2(BEEP_DIV) : 3;

  localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_CYC - 1);
  localparam logic [SLOT_W-1:0] DRIVE_LAST = SLOT_W'(DRIVE_CYC - 1);
  localparam logic [TONE_W-1:0] TONE_LAST  = TONE_W'(HALF_CYC - 1);
  localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(STEP_CYC - 1);
  localparam logic [BEEP_W-1:0] BEEP_LAST  = BEEP_W'(BEEP_DIV - 1);

  typedef enum logic {BLANK, DRIVE} scan_state_t;

  scan_state_t       state, state_next;
  logic [SLOT_W-1:0] slot_cnt, slot_cnt_next;
  logic [1:0]        digit, digit_next;
  logic [3:0]        slot_nib, slot_nib_next;
  logic              slot_colon, slot_colon_next;

  logic [6:0]        seg_n_next;
  logic [3:0]        an_n_next;
  logic              dp_n_next;

  logic [TONE_W-1:0] tone_cnt;
  logic              tone;
  logic [STEP_W-1:0] step_cnt;
  logic [BEEP_W-1:0] beep_step;
  logic              beep_on;

  // Segment patterns, active-low, bit 0 = a. Codes A..F are the clock's
  // status glyphs ('F', 'n', '-', 'A', 'E', blank), not hex letters.
  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'h0:    return 7'h40;
      4'h1:    return 7'h79;
      4'h2:    return 7'h24;
      4'h3:    return 7'h30;
      4'h4:    return 7'h19;
      4'h5:    return 7'h12;
      4'h6:    return 7'h02;
      4'h7:    return 7'h78;
      4'h8:    return 7'h00;
      4'h9:    return 7'h10;
      4'hA:    return 7'h0E;
      4'hB:    return 7'h2B;
      4'hC:    return 7'h3F;
      4'hD:    return 7'h08;
      4'hE:    return 7'h06;
      default: return 7'h7F;
    endcase
  endfunction

  // State register. The display outputs are registered here too, from values
  // computed against the next state, so AN_N/SEG_N move on exactly the same
  // edge as the BLANK/DRIVE transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BLANK;
      slot_cnt   <= '0;
      digit      <= 2'd0;
      slot_nib   <= 4'hF;
      slot_colon <= 1'b0;
      bus.an_n   <= 4'b1111;
      bus.seg_n  <= 7'h7F;
      bus.dp_n   <= 1'b1;
    end else begin
      state      <= state_next;
      slot_cnt   <= slot_cnt_next;
      digit      <= digit_next;
      slot_nib   <= slot_nib_next;
      slot_colon <= slot_colon_next;
      bus.an_n   <= an_n_next;
      bus.seg_n  <= seg_n_next;
      bus.dp_n   <= dp_n_next;
    end
  end

  // Next-state logic. The digit code and colon are captured only on the
  // first blank cycle, so mid-slot input changes never reach the segments.
  always_comb begin
    state_next      = state;
    slot_cnt_next   = slot_cnt + SLOT_W'(1);
    digit_next      = digit;
    slot_nib_next   = slot_nib;
    slot_colon_next = slot_colon;
    case (state)
      BLANK: begin
        if (slot_cnt == '0) begin
          case (digit)
            2'd0:    slot_nib_next = bus.l1;
            2'd1:    slot_nib_next = bus.l2;
            2'd2:    slot_nib_next = bus.l3;
            default: slot_nib_next = bus.l4;
          endcase
          slot_colon_next = bus.colon;
        end
        if (slot_cnt == BLANK_LAST) begin
          state_next    = DRIVE;
          slot_cnt_next = '0;
        end
      end
      default: begin
        if (slot_cnt == DRIVE_LAST) begin
          state_next    = BLANK;
          slot_cnt_next = '0;
          digit_next    = digit + 2'd1;
        end
      end
    endcase
  end

  // Output logic, evaluated on the next-state values.
  always_comb begin
    an_n_next  = 4'b1111;
    seg_n_next = 7'h7F;
    dp_n_next  = 1'b1;
    if (state_next == DRIVE) begin
      an_n_next  = ~(4'b0001 << digit_next);
      seg_n_next = decode(slot_nib_next);
      dp_n_next  = ~(slot_colon_next & (digit_next == 2'd2));
    end
  end

  // Four beeps (steps 0, 2, 4, 6) followed by silence.
  assign beep_on = (beep_step < BEEP_W'(7)) && !beep_step[0];

  // Buzzer. Everything is held at zero while the alarm is off, so each rising
  // edge of alarm_state restarts both the beep pattern and the tone phase.
  always_ff @(posedge clk) begin
    if (reset || !bus.alarm_state) begin
      tone_cnt  <= '0;
      tone      <= 1'b0;
      step_cnt  <= '0;
      beep_step <= '0;
      bus.buzz  <= 1'b0;
    end else begin
      if (tone_cnt == TONE_LAST) begin
        tone_cnt <= '0;
        tone     <= ~tone;
      end else begin
        tone_cnt <= tone_cnt + TONE_W'(1);
      end
      if (step_cnt == STEP_LAST) begin
        step_cnt  <= '0;
        beep_step <= (beep_step == BEEP_LAST) ? '0 : beep_step + BEEP_W'(1);
      end else begin
        step_cnt <= step_cnt + STEP_W'(1);
      end
      bus.buzz <= beep_on & tone;
    end
  end

endmodule
